// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter states, frame bit values and keyboard command bytes.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INHIBIT,
        ST_RTS,
        ST_SHIFT,
        ST_ACK,
        ST_WAIT_IDLE
    } tx_state_e;

    localparam logic START      = 1'b0;
    localparam logic STOP       = 1'b1;
    localparam logic ODD_PARITY = 1'b1;

    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_RESET   = 8'hFF;
    localparam logic [7:0] RSP_ACK     = 8'hFA;

    // Parity bit that makes the total count of ones in data+parity odd.
    function automatic logic odd_parity(input logic [7:0] data);
        return ODD_PARITY ^ (^data);
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Multi-stage synchroniser for one asynchronous PS/2 pad line, with a registered falling-edge pulse.
module ps2_line_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic fall
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;
    logic              fall_q, fall_d;

    always_comb begin
        sync_d = STAGES'({sync_q, d});
        prev_d = sync_q[STAGES-1];
        fall_d = prev_q & ~sync_q[STAGES-1];
    end

    // Idle PS/2 lines float high, so the chain resets to 1 to avoid a spurious fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
            prev_q <= 1'b1;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            fall_q <= fall_d;
        end
    end

    assign q    = sync_q[STAGES-1];
    assign fall = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, shift one byte on the device clock,
// then check the device ACK. Lines are driven open-drain through the *_oe outputs.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       PS2_KBCLK,
    input  logic       PS2_KBDAT,
    output logic       kbclk_oe,
    output logic       kbdat_oe,
    output logic       tx_active,
    output logic       done,
    output logic       ack_err,
    output logic       timeout_err
);

    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IW-1:0] INHIBIT_LAST = IW'(INHIBIT_CYCLES - 1);
    localparam logic [WW-1:0] TIMEOUT_LAST = WW'(TIMEOUT_CYCLES - 1);

    logic clk_sync, clk_fall;
    logic dat_sync, dat_fall_unused;

    ps2_line_sync #(.STAGES(SYNC_STAGES)) u_clk_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (PS2_KBCLK),
        .q    (clk_sync),
        .fall (clk_fall)
    );

    ps2_line_sync #(.STAGES(SYNC_STAGES)) u_dat_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (PS2_KBDAT),
        .q    (dat_sync),
        .fall (dat_fall_unused)
    );

    tx_state_e     state_q, state_d;
    logic [9:0]    shift_q, shift_d;
    logic [3:0]    edge_cnt_q, edge_cnt_d;
    logic [IW-1:0] inhibit_cnt_q, inhibit_cnt_d;
    logic [WW-1:0] wd_cnt_q, wd_cnt_d;
    logic          ack_bad_q, ack_bad_d;
    logic          tx_ready_q, tx_ready_d;
    logic          tx_active_q, tx_active_d;
    logic          kbclk_oe_q, kbclk_oe_d;
    logic          kbdat_oe_q, kbdat_oe_d;
    logic          done_q, done_d;
    logic          ack_err_q, ack_err_d;
    logic          timeout_err_q, timeout_err_d;

    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        edge_cnt_d    = edge_cnt_q;
        inhibit_cnt_d = inhibit_cnt_q;
        wd_cnt_d      = wd_cnt_q;
        ack_bad_d     = ack_bad_q;
        tx_ready_d    = tx_ready_q;
        tx_active_d   = tx_active_q;
        kbclk_oe_d    = kbclk_oe_q;
        kbdat_oe_d    = kbdat_oe_q;
        done_d        = 1'b0;
        ack_err_d     = 1'b0;
        timeout_err_d = 1'b0;

        if (state_q inside {ST_RTS, ST_SHIFT, ST_ACK, ST_WAIT_IDLE}) begin
            wd_cnt_d = wd_cnt_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (tx_valid && tx_ready_q) begin
                    shift_d       = {STOP, odd_parity(tx_data), tx_data};
                    edge_cnt_d    = 4'd0;
                    inhibit_cnt_d = '0;
                    ack_bad_d     = 1'b0;
                    kbclk_oe_d    = 1'b1;
                    tx_ready_d    = 1'b0;
                    tx_active_d   = 1'b1;
                    state_d       = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                inhibit_cnt_d = inhibit_cnt_q + 1'b1;
                if (inhibit_cnt_q == INHIBIT_LAST) begin
                    kbclk_oe_d = 1'b0;
                    kbdat_oe_d = ~START;
                    wd_cnt_d   = '0;
                    state_d    = ST_RTS;
                end
            end
            // A fall already seen in RTS is the device's first clock, not noise.
            ST_RTS, ST_SHIFT: begin
                if (clk_fall) begin
                    kbdat_oe_d = ~shift_q[0];
                    shift_d    = {STOP, shift_q[9:1]};
                    edge_cnt_d = edge_cnt_q + 4'd1;
                    state_d    = (edge_cnt_q == 4'd9) ? ST_ACK : ST_SHIFT;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_ACK: begin
                if (clk_fall) begin
                    edge_cnt_d = edge_cnt_q + 4'd1;
                    ack_bad_d  = dat_sync;
                    state_d    = ST_WAIT_IDLE;
                end
            end
            ST_WAIT_IDLE: begin
                if (clk_sync && dat_sync) begin
                    done_d      = 1'b1;
                    ack_err_d   = ack_bad_q;
                    tx_ready_d  = 1'b1;
                    tx_active_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Watchdog abort wins over any progress made in the same cycle.
        if (state_q inside {ST_RTS, ST_SHIFT, ST_ACK, ST_WAIT_IDLE} && wd_cnt_q == TIMEOUT_LAST) begin
            kbclk_oe_d    = 1'b0;
            kbdat_oe_d    = 1'b0;
            timeout_err_d = 1'b1;
            done_d        = 1'b0;
            ack_err_d     = 1'b0;
            tx_ready_d    = 1'b1;
            tx_active_d   = 1'b0;
            state_d       = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            shift_q       <= '0;
            edge_cnt_q    <= '0;
            inhibit_cnt_q <= '0;
            wd_cnt_q      <= '0;
            ack_bad_q     <= 1'b0;
            tx_ready_q    <= 1'b1;
            tx_active_q   <= 1'b0;
            kbclk_oe_q    <= 1'b0;
            kbdat_oe_q    <= 1'b0;
            done_q        <= 1'b0;
            ack_err_q     <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            shift_q       <= shift_d;
            edge_cnt_q    <= edge_cnt_d;
            inhibit_cnt_q <= inhibit_cnt_d;
            wd_cnt_q      <= wd_cnt_d;
            ack_bad_q     <= ack_bad_d;
            tx_ready_q    <= tx_ready_d;
            tx_active_q   <= tx_active_d;
            kbclk_oe_q    <= kbclk_oe_d;
            kbdat_oe_q    <= kbdat_oe_d;
            done_q        <= done_d;
            ack_err_q     <= ack_err_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign tx_ready    = tx_ready_q;
    assign tx_active   = tx_active_q;
    assign kbclk_oe    = kbclk_oe_q;
    assign kbdat_oe    = kbdat_oe_q;
    assign done        = done_q;
    assign ack_err     = ack_err_q;
    assign timeout_err = timeout_err_q;

endmodule
